hall_decoder: RTL



---
 rtl/bldc_pkg.sv | 27 ++
 rtl/hall_debounce.sv | 37 +++
 rtl/hall_decoder.sv | 79 +++++++
 3 files changed

// File: rtl/bldc_pkg.sv
// bldc_pkg: hall code constants and decode helpers shared by the BLDC hall front end and commutation logic.
package bldc_pkg;
  localparam logic [2:0] HALL_S0   = 3'b001;
  localparam logic [2:0] HALL_S1   = 3'b101;
  localparam logic [2:0] HALL_S2   = 3'b100;
  localparam logic [2:0] HALL_S3   = 3'b110;
  localparam logic [2:0] HALL_S4   = 3'b010;
  localparam logic [2:0] HALL_S5   = 3'b011;
  localparam logic [2:0] HALL_BAD0 = 3'b000;
  localparam logic [2:0] HALL_BAD7 = 3'b111;

  function automatic logic hall_is_valid(input logic [2:0] h);
    return (h != HALL_BAD0) && (h != HALL_BAD7);
  endfunction

  function automatic logic [2:0] hall_to_sector(input logic [2:0] h);
    case (h)
      HALL_S0: return 3'd0;
      HALL_S1: return 3'd1;
      HALL_S2: return 3'd2;
      HALL_S3: return 3'd3;
      HALL_S4: return 3'd4;
      HALL_S5: return 3'd5;
      default: return 3'd0;
    endcase
  endfunction
endpackage

// File: rtl/hall_debounce.sv
// hall_debounce: 2-flop synchroniser plus stable-sample counter; strobes accept when a new code has held DEB_CYCLES samples.
module hall_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hall_i,
  output logic [2:0] code_o,
  output logic       accept_o
);
  localparam logic [3:0] DEB = 4'(DEB_CYCLES);

  logic [2:0] s1_q, s2_q, cand_q, hq_q;
  logic [3:0] dcnt_q, dcnt_d;

  always_comb dcnt_d = (s2_q != cand_q) ? 4'd1 : (dcnt_q == DEB) ? dcnt_q : dcnt_q + 4'd1;

  // Accept is combinational so the top can register its outputs on the same edge hq loads.
  assign accept_o = (dcnt_q == DEB) && (cand_q != hq_q);
  assign code_o   = cand_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      dcnt_q <= '0;
      hq_q   <= '0;
    end else begin
      s1_q   <= hall_i;
      s2_q   <= s1_q;
      cand_q <= s2_q;
      dcnt_q <= dcnt_d;
      if (accept_o) hq_q <= cand_q;
    end
  end
endmodule

// File: rtl/hall_decoder.sv
// hall_decoder: debounced hall decode into sector, direction, commutation period, stall and fault flags.
module hall_decoder
  import bldc_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int PER_W      = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       hall,
  output logic [2:0]       sector,
  output logic             sector_valid,
  output logic             dir,
  output logic             edge_pulse,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             stall,
  output logic             fault,
  output logic             seq_err
);
  localparam logic [PER_W-1:0] PMAX = '1;
  localparam logic [PER_W-1:0] ONE  = 1;

  logic [2:0]       code, new_sec, nxt_sec, prv_sec;
  logic             accept, new_valid, v2v, i2v, fwd, rev;
  logic             known_q, had_edge_q;
  logic [PER_W-1:0] pcnt_q, pcnt_d;

  hall_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .hall_i  (hall),
    .code_o  (code),
    .accept_o(accept)
  );

  always_comb begin
    new_valid = hall_is_valid(code);
    new_sec   = hall_to_sector(code);
    nxt_sec   = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
    prv_sec   = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
    fwd       = new_sec == nxt_sec;
    rev       = new_sec == prv_sec;
    v2v       = accept && known_q && sector_valid && new_valid;
    i2v       = accept && known_q && !sector_valid && new_valid;
    pcnt_d    = v2v ? ONE : (pcnt_q == PMAX) ? pcnt_q : pcnt_q + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      known_q      <= 1'b0;
      had_edge_q   <= 1'b0;
      pcnt_q       <= '0;
      sector       <= '0;
      sector_valid <= 1'b0;
      dir          <= 1'b1;
      edge_pulse   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b0;
      fault        <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      known_q      <= known_q | accept;
      had_edge_q   <= had_edge_q | v2v;
      pcnt_q       <= pcnt_d;
      sector       <= (accept && new_valid) ? new_sec : sector;
      sector_valid <= accept ? new_valid : sector_valid;
      fault        <= accept ? !new_valid : fault;
      dir          <= (v2v && fwd) ? 1'b1 : (v2v && rev) ? 1'b0 : dir;
      edge_pulse   <= v2v;
      seq_err      <= v2v && !fwd && !rev;
      period       <= v2v ? pcnt_q : period;
      // An edge decides period_valid on its own; otherwise return-from-fault or saturation clears it.
      period_valid <= v2v ? (had_edge_q && pcnt_q != PMAX) : (i2v || pcnt_d == PMAX) ? 1'b0 : period_valid;
      stall        <= pcnt_d == PMAX;
    end
  end
endmodule
